// File: rtl/cpu_sched_pkg.sv
// Shared types for the CPU command scheduler: command encoding, FSM states
// and the AXI response codes the scheduler reports back to the host.
package cpu_sched_pkg;

  typedef enum logic [1:0] {
    CMD_MEM_WR = 2'b00,
    CMD_MEM_RD = 2'b01,
    CMD_SPI_WR = 2'b10,
    CMD_SPI_RD = 2'b11
  } cmd_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_RESP
  } sched_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Bit 0 of the command type distinguishes reads from writes for both targets.
  function automatic logic is_read(input cmd_type_e t);
    return t[0];
  endfunction

endpackage

// File: rtl/sched_cmd_fifo.sv
// Synchronous command FIFO with an occupancy count; DEPTH must be a power of two.
// Pushes into a full FIFO and pops from an empty one are dropped.
module sched_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int              AW         = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_q == FULL_COUNT);
  assign empty    = (count_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];
  assign count    = count_q;

  // NOTE: the storage array is deliberately not reset; the pointers and count
  // define which entries are valid, so clearing the data would only cost logic.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/cpu_cmd_scheduler.sv
// Sequences buffered memory/SPI commands through the AXI-Lite CPU master one at a
// time and returns one response per command. Optional watchdog: CPU_SCHED_TIMEOUT_EN.
module cpu_cmd_scheduler
  import cpu_sched_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [1:0]                  cmd_type,
  input  logic [ADDR_WIDTH-1:0]       cmd_addr,
  input  logic [DATA_WIDTH-1:0]       cmd_wdata,
  output logic                        start_test,
  output logic [1:0]                  ins_type,
  output logic [ADDR_WIDTH-1:0]       address,
  output logic [DATA_WIDTH-1:0]       data_to_write,
  output logic                        start_write,
  output logic                        start_read,
  input  logic                        test_done,
  input  logic                        mon_bvalid,
  input  logic                        mon_bready,
  input  logic [1:0]                  mon_bresp,
  input  logic                        mon_rvalid,
  input  logic                        mon_rready,
  input  logic [1:0]                  mon_rresp,
  input  logic [DATA_WIDTH-1:0]       mon_rdata,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [DATA_WIDTH-1:0]       rsp_data,
  output logic [1:0]                  rsp_resp,
  output logic                        rsp_is_read,
  output logic                        busy,
`ifdef CPU_SCHED_TIMEOUT_EN
  output logic                        master_rst_req,
`endif
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int ENTRY_W = 2 + ADDR_WIDTH + DATA_WIDTH;

  sched_state_e          state_q, state_d;
  cmd_type_e             cur_type;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0] cur_wdata;
  logic [DATA_WIDTH-1:0] cap_data;
  logic [1:0]            cap_resp;
  logic [ENTRY_W-1:0]    head;
  logic                  fifo_full, fifo_empty, pop;
  logic                  expire;

  sched_cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cmd_valid),
    .push_data ({cmd_type, cmd_addr, cmd_wdata}),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

`ifdef CPU_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer_q;

  always_ff @(posedge clk) begin
    if (rst || state_q != ST_WAIT) timer_q <= '0;
    else                           timer_q <= timer_q + TW'(1);
  end

  // A test_done arriving in the expiry cycle still wins over the watchdog.
  assign expire         = (state_q == ST_WAIT) && !test_done &&
                          (timer_q == TW'(TIMEOUT_CYCLES - 1));
  assign master_rst_req = expire;
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    start_test  = 1'b0;
    start_write = 1'b0;
    start_read  = 1'b0;
    rsp_valid   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        start_test = 1'b1;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        start_write = !is_read(cur_type);
        start_read  = is_read(cur_type);
        if (test_done || expire) state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture only the channel matching the command so a write always reports zero data.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_type  <= CMD_MEM_WR;
      cur_addr  <= '0;
      cur_wdata <= '0;
      cap_data  <= '0;
      cap_resp  <= RESP_OKAY;
    end else begin
      if (pop) begin
        cur_type  <= cmd_type_e'(head[ENTRY_W-1 -: 2]);
        cur_addr  <= head[DATA_WIDTH +: ADDR_WIDTH];
        cur_wdata <= head[DATA_WIDTH-1:0];
      end
      if (state_q == ST_IDLE) begin
        cap_data <= '0;
        cap_resp <= RESP_OKAY;
      end else if (state_q == ST_WAIT) begin
        if (expire) begin
          cap_data <= '0;
          cap_resp <= RESP_SLVERR;
        end else begin
          if (mon_bvalid && mon_bready && !is_read(cur_type)) cap_resp <= mon_bresp;
          if (mon_rvalid && mon_rready && is_read(cur_type)) begin
            cap_resp <= mon_rresp;
            cap_data <= mon_rdata;
          end
        end
      end
    end
  end

  assign cmd_ready     = !fifo_full;
  assign ins_type      = cur_type;
  assign address       = cur_addr;
  assign data_to_write = cur_wdata;
  assign rsp_data      = cap_data;
  assign rsp_resp      = cap_resp;
  assign rsp_is_read   = is_read(cur_type);
  assign busy          = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_cpu_cmd_scheduler.sv
// Self-checking bench for cpu_cmd_scheduler: directed scenarios plus randomized
// commands, with a command queue model and a scripted AXI master response.
module tb_cpu_cmd_scheduler;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int TO    = 16;

  typedef struct packed {
    logic [1:0]    t;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } cmd_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_type;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          start_test, start_write, start_read;
  logic [1:0]    ins_type;
  logic [AW-1:0] address;
  logic [DW-1:0] data_to_write;
  logic          test_done;
  logic          mon_bvalid, mon_bready, mon_rvalid, mon_rready;
  logic [1:0]    mon_bresp, mon_rresp;
  logic [DW-1:0] mon_rdata;
  logic          rsp_valid, rsp_ready, rsp_is_read, busy;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_resp;
  logic [$clog2(DEPTH):0] fifo_count;
`ifdef CPU_SCHED_TIMEOUT_EN
  logic          master_rst_req;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  cmd_t model_q[$];

  cpu_cmd_scheduler #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .start_test(start_test), .ins_type(ins_type), .address(address),
    .data_to_write(data_to_write), .start_write(start_write), .start_read(start_read),
    .test_done(test_done),
    .mon_bvalid(mon_bvalid), .mon_bready(mon_bready), .mon_bresp(mon_bresp),
    .mon_rvalid(mon_rvalid), .mon_rready(mon_rready), .mon_rresp(mon_rresp),
    .mon_rdata(mon_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_resp(rsp_resp), .rsp_is_read(rsp_is_read), .busy(busy),
`ifdef CPU_SCHED_TIMEOUT_EN
    .master_rst_req(master_rst_req),
`endif
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_cmd_ready"},   cmd_ready, 1);
    check({pfx, "_start_test"},  start_test, 0);
    check({pfx, "_start_write"}, start_write, 0);
    check({pfx, "_start_read"},  start_read, 0);
    check({pfx, "_ins_type"},    ins_type, 0);
    check({pfx, "_address"},     address, 0);
    check({pfx, "_wdata"},       data_to_write, 0);
    check({pfx, "_rsp_valid"},   rsp_valid, 0);
    check({pfx, "_rsp_data"},    rsp_data, 0);
    check({pfx, "_rsp_resp"},    rsp_resp, 0);
    check({pfx, "_rsp_is_read"}, rsp_is_read, 0);
    check({pfx, "_busy"},        busy, 0);
    check({pfx, "_fifo_count"},  fifo_count, 0);
`ifdef CPU_SCHED_TIMEOUT_EN
    check({pfx, "_master_rst_req"}, master_rst_req, 0);
`endif
  endtask

  task automatic clear_mon();
    mon_bvalid = 0; mon_bready = 0; mon_bresp = 0;
    mon_rvalid = 0; mon_rready = 0; mon_rresp = 0; mon_rdata = 0;
  endtask

  // Starts and ends on a falling edge; the command is accepted at the rising edge between.
  task automatic push_cmd(input logic [1:0] t, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int g = 0;
    cmd_valid = 1; cmd_type = t; cmd_addr = a; cmd_wdata = d;
    while (cmd_ready !== 1'b1 && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("push_ready_seen", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 0;
    model_q.push_back('{t: t, a: a, d: d});
  endtask

  // Returns on the falling edge where start_test is high; checks the launched command.
  task automatic wait_launch(output cmd_t e);
    int g = 0;
    while (start_test !== 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("launch_seen", start_test, 1);
    if (model_q.size() != 0) e = model_q.pop_front();
    else                     e = '0;
    check("launch_ins_type", ins_type, e.t);
    check("launch_address",  address, e.a);
    check("launch_wdata",    data_to_write, e.d);
  endtask

  // Plays the master for a launched command, then checks and drains its response.
  task automatic finish_cmd(input cmd_t e, input logic [1:0] resp, input logic [DW-1:0] rdata,
                            input int lat, input int hold);
    logic [DW-1:0] exp_data;
    logic          rd;
    rd       = e.t[0];
    exp_data = rd ? rdata : '0;
    @(negedge clk);
    check("wait_start_test_low", start_test, 0);
    check("wait_start_write", start_write, !rd);
    check("wait_start_read",  start_read, rd);
    repeat (lat) @(negedge clk);
    if (rd) begin
      mon_rvalid = 1; mon_rready = 1; mon_rdata = rdata; mon_rresp = resp;
    end else begin
      mon_bvalid = 1; mon_bready = 1; mon_bresp = resp;
    end
    @(negedge clk);
    clear_mon();
    test_done = 1;
    @(negedge clk);
    test_done = 0;
    check("rsp_valid",    rsp_valid, 1);
    check("rsp_data",     rsp_data, exp_data);
    check("rsp_resp",     rsp_resp, resp);
    check("rsp_is_read",  rsp_is_read, rd);
    check("rsp_addr_held", address, e.a);
    check("rsp_start_levels_low", {start_write, start_read}, 0);
    for (int i = 0; i < hold; i++) begin
      if (i == 0) begin
        mon_rvalid = 1; mon_rready = 1; mon_rdata = ~rdata; mon_rresp = ~resp;
        mon_bvalid = 1; mon_bready = 1; mon_bresp = ~resp;
        test_done  = 1;
      end
      @(negedge clk);
      clear_mon();
      test_done = 0;
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rsp_data",  rsp_data, exp_data);
      check("hold_rsp_resp",  rsp_resp, resp);
      check("hold_no_launch", start_test, 0);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    check("rsp_valid_drop", rsp_valid, 0);
  endtask

  cmd_t e;

  initial begin
    rst = 1; cmd_valid = 0; cmd_type = 0; cmd_addr = 0; cmd_wdata = 0;
    test_done = 0; rsp_ready = 0;
    clear_mon();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 0;
    @(negedge clk);

    // A completion pulse while idle must not produce a response.
    test_done = 1;
    @(negedge clk);
    test_done = 0;
    @(negedge clk);
    check("idle_done_rsp_valid", rsp_valid, 0);
    check("idle_done_busy", busy, 0);

    // Single memory write with exact launch timing.
    push_cmd(2'b00, 32'h10, 32'hDEADBEEF);
    check("wr_count_after_push", fifo_count, 1);
    check("wr_no_early_launch", start_test, 0);
    check("wr_busy", busy, 1);
    @(negedge clk);
    check("wr_launch_at_n2", start_test, 1);
    wait_launch(e);
    finish_cmd(e, 2'b00, 32'h0, 2, 2);

    // SPI read returning 0xA5.
    push_cmd(2'b11, 32'h4000_0000, 32'h1234_5678);
    @(negedge clk);
    wait_launch(e);
    finish_cmd(e, 2'b00, 32'h0000_00A5, 1, 1);
    check("idle_after_read_busy", busy, 0);

    // FIFO fill with backpressure: five accepted, the sixth waits for a free slot.
    push_cmd(2'b00, 32'h100, 32'hA0);
    push_cmd(2'b01, 32'h104, 32'hA1);
    wait_launch(e);
    push_cmd(2'b10, 32'h108, 32'hA2);
    push_cmd(2'b11, 32'h10C, 32'hA3);
    push_cmd(2'b00, 32'h110, 32'hA4);
    check("full_count", fifo_count, 4);
    check("full_cmd_ready", cmd_ready, 0);
    cmd_valid = 1; cmd_type = 2'b01; cmd_addr = 32'h114; cmd_wdata = 32'hA5;
    model_q.push_back('{t: 2'b01, a: 32'h114, d: 32'hA5});
    repeat (3) begin
      @(negedge clk);
      check("full_refuse_ready", cmd_ready, 0);
      check("full_refuse_count", fifo_count, 4);
    end
    finish_cmd(e, 2'b10, 32'h0, 1, 10);
    check("full_after_hs_ready", cmd_ready, 0);
    @(negedge clk);
    check("full_pop_ready", cmd_ready, 1);
    check("full_pop_count", fifo_count, 3);
    wait_launch(e);
    @(negedge clk);
    cmd_valid = 0;
    check("full_sixth_accepted", fifo_count, 4);
    finish_cmd(e, 2'b01, $urandom, 1, 0);
    for (int i = 0; i < 4; i++) begin
      cmd_t q;
      wait_launch(q);
      finish_cmd(q, 2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 3),
                 $urandom_range(0, 2));
    end
    check("drain_busy", busy, 0);

    // Reset while a read is in its wait phase, with another command queued.
    push_cmd(2'b11, 32'h200, 32'h0);
    push_cmd(2'b00, 32'h204, 32'h55);
    wait_launch(e);
    @(negedge clk);
    check("mid_rst_in_wait", start_read, 1);
    rst = 1;
    @(negedge clk);
    check_reset_outputs("mid_rst");
    rst = 0;
    model_q.delete();
    repeat (4) @(negedge clk);
    check("post_rst_no_rsp", rsp_valid, 0);
    check("post_rst_no_launch", start_test, 0);
    check("post_rst_busy", busy, 0);

    // Randomized single commands against the queue model.
    for (int i = 0; i < 12; i++) begin
      push_cmd(2'($urandom_range(0, 3)), $urandom, $urandom);
      @(negedge clk);
      wait_launch(e);
      finish_cmd(e, 2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 4),
                 $urandom_range(0, 3));
    end

`ifdef CPU_SCHED_TIMEOUT_EN
    begin
      int k = 0;
      push_cmd(2'b00, 32'h300, 32'h77);
      @(negedge clk);
      wait_launch(e);
      @(negedge clk);
      while (master_rst_req !== 1'b1 && k < 4 * TO) begin
        @(negedge clk);
        k++;
      end
      check("to_expiry_cycle", k, TO - 1);
      @(negedge clk);
      check("to_pulse_single", master_rst_req, 0);
      check("to_rsp_valid", rsp_valid, 1);
      check("to_rsp_resp", rsp_resp, 2'b10);
      check("to_rsp_data", rsp_data, 0);
      rsp_ready = 1;
      @(negedge clk);
      rsp_ready = 0;
      check("to_rsp_drop", rsp_valid, 0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
